// File: rtl/uart_tx_arbiter_if.sv
// Signal bundle between the UART TX arbiter, its requesters and the transmitter.
// The master side is the arbiter; the slave side is the surrounding environment.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]   req_valid;
  logic [NUM_REQ*8-1:0] req_data;
  logic [NUM_REQ-1:0]   req_done;
  logic                 tx_send;
  logic [7:0]           tx_data;
  logic                 tx_sent;
  logic [GW-1:0]        grant_id;
  logic                 busy;
  logic                 err;

  modport master (
    input  req_valid, req_data, tx_sent,
    output req_done, tx_send, tx_data, grant_id, busy, err
  );

  modport slave (
    output req_valid, req_data, tx_sent,
    input  req_done, tx_send, tx_data, grant_id, busy, err
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// using a four-phase send/sent handshake with an acknowledge timeout.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                     clk,
  input  logic                     rst_n,
  uart_tx_arbiter_if.master        bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [15:0] TIMEOUT_LAST = 16'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SEND    = 2'd1,
    RELEASE = 2'd2
  } arbState;

  arbState            stateReg, stateNext;
  logic               txSendReg, txSendNext;
  logic [7:0]         txDataReg, txDataNext;
  logic [GW-1:0]      grantReg, grantNext;
  logic [GW-1:0]      lastReg, lastNext;
  logic [15:0]        waitReg, waitNext;
  logic [NUM_REQ-1:0] doneReg, doneNext;
  logic               errReg, errNext;
  logic               busyReg;

  logic [7:0]         reqByte [NUM_REQ];
  logic               pickFound;
  logic [GW-1:0]      pickIdx;
  logic [GW-1:0]      candIdx;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_REQ; gi++) begin : gByte
      assign reqByte[gi] = bus.req_data[8*gi +: 8];
    end
  endgenerate

  // Scan upward from the requester after the last grant, wrapping at NUM_REQ.
  always_comb begin
    pickFound = 1'b0;
    pickIdx   = '0;
    candIdx   = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (int'(lastReg) + k >= NUM_REQ) begin
        candIdx = GW'(int'(lastReg) + k - NUM_REQ);
      end else begin
        candIdx = GW'(int'(lastReg) + k);
      end
      if (!pickFound && bus.req_valid[candIdx]) begin
        pickFound = 1'b1;
        pickIdx   = candIdx;
      end
    end
  end

  always_comb begin
    stateNext  = stateReg;
    txSendNext = txSendReg;
    txDataNext = txDataReg;
    grantNext  = grantReg;
    lastNext   = lastReg;
    waitNext   = waitReg;
    doneNext   = '0;
    errNext    = 1'b0;
    case (stateReg)
      IDLE: begin
        // A lingering acknowledge from the previous byte blocks any new grant.
        if (pickFound && !bus.tx_sent) begin
          stateNext  = SEND;
          txSendNext = 1'b1;
          txDataNext = reqByte[pickIdx];
          grantNext  = pickIdx;
          waitNext   = '0;
        end
      end
      SEND: begin
        if (bus.tx_sent) begin
          txSendNext = 1'b0;
          stateNext  = RELEASE;
        end else if (waitReg == TIMEOUT_LAST) begin
          txSendNext = 1'b0;
          errNext    = 1'b1;
          stateNext  = RELEASE;
        end else begin
          waitNext = waitReg + 16'd1;
        end
      end
      RELEASE: begin
        txSendNext = 1'b0;
        if (!bus.tx_sent) begin
          doneNext[grantReg] = 1'b1;
          lastNext           = grantReg;
          stateNext          = IDLE;
        end
      end
      default: begin
        stateNext  = IDLE;
        txSendNext = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stateReg  <= IDLE;
      txSendReg <= 1'b0;
      txDataReg <= '0;
      grantReg  <= '0;
      lastReg   <= GW'(NUM_REQ - 1);
      waitReg   <= '0;
      doneReg   <= '0;
      errReg    <= 1'b0;
      busyReg   <= 1'b0;
    end else begin
      stateReg  <= stateNext;
      txSendReg <= txSendNext;
      txDataReg <= txDataNext;
      grantReg  <= grantNext;
      lastReg   <= lastNext;
      waitReg   <= waitNext;
      doneReg   <= doneNext;
      errReg    <= errNext;
      busyReg   <= (stateNext != IDLE);
    end
  end

  assign bus.tx_send  = txSendReg;
  assign bus.tx_data  = txDataReg;
  assign bus.grant_id = grantReg;
  assign bus.req_done = doneReg;
  assign bus.err      = errReg;
  assign bus.busy     = busyReg;
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-002 The block SHALL have parameter TIMEOUT_CYC, default 65535, giving the maximum cycles to wait for tx_sent (16-bit).
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 req_valid  input  NUM_REQ  per-requester byte-pending flag.
REQ-006 req_data  input  NUM_REQ*8  requester i byte in bits [8i+7:8i].
REQ-007 req_done  output  NUM_REQ  one-cycle pulse to the requester whose byte finished.
REQ-008 tx_send  output  1  send request to the UART transmitter.
REQ-009 tx_data  output  8  byte presented to the transmitter.
REQ-010 tx_sent  input  1  transmitter acknowledge; level, four-phase.
REQ-011 grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 err  output  1  one-cycle pulse on acknowledge timeout.

Function
REQ-014 The block SHALL use states IDLE, SEND, RELEASE with registered outputs.
REQ-015 IDLE: when any req_valid bit is high, the block SHALL pick the first set bit searching upward from (last_grant+1) mod NUM_REQ, wrapping at NUM_REQ-1 to 0.
REQ-016 The block SHALL latch the granted byte into tx_data, set grant_id, and move to SEND on the same edge; tx_send is high one cycle after req_valid is sampled.
REQ-017 SEND: tx_send=1 and tx_data SHALL stay stable; changes to req_data or req_valid SHALL have no effect.
REQ-018 SEND with tx_sent=1 sampled: the block SHALL clear tx_send on that edge and enter RELEASE.
REQ-019 SEND: a 16-bit wait counter SHALL clear on SEND entry and increment each SEND cycle.
REQ-020 SEND with wait counter == TIMEOUT_CYC-1 and tx_sent=0: the block SHALL clear tx_send, pulse err for one cycle, and enter RELEASE.
REQ-021 RELEASE: tx_send=0; the block SHALL remain in RELEASE until tx_sent=0 is sampled.
REQ-022 On leaving RELEASE, the block SHALL pulse req_done[grant_id] for exactly one cycle, set last_grant=grant_id, and enter IDLE.
REQ-023 The done pulse SHALL occur after a timeout as well (err distinguishes the case).
REQ-024 The requester SHALL drop req_valid in the cycle after req_done is seen; req_valid still high in IDLE is a new request.
REQ-025 req_valid falling mid-transfer SHALL NOT abort the transfer; done still pulses.
REQ-026 tx_sent high while in IDLE SHALL be ignored; the grant waits for it to drop.
REQ-027 The block SHALL issue no grant while tx_sent=1 in IDLE.
REQ-028 At most one req_done bit SHALL be high in any cycle, and never while tx_send=1.
REQ-029 Unreachable state encodings SHALL return to IDLE on the next edge.

Reset
REQ-030 rst_n=0 sampled at any edge, including mid-transfer, SHALL force state IDLE, tx_send=0, tx_data=0, req_done=0, err=0, busy=0, grant_id=0, and wait counter=0.
REQ-031 Reset SHALL set last_grant=NUM_REQ-1 so requester 0 has first priority after reset.
REQ-032 An interrupted byte SHALL NOT produce req_done.

Verification
REQ-033 Single request: req_valid=4'b0010, data 0x5A -> tx_send rises the next cycle with tx_data=0x5A and grant_id=1; tx_sent up/down -> req_done=4'b0010 for one cycle.
REQ-034 Round-robin: all four valid continuously, transmitter model acks -> grant order 0,1,2,3,0 with no requester granted twice in a row.
REQ-035 Data stability: req_data changes to 0xFF during SEND -> tx_data stays at the latched value until RELEASE exits.
REQ-036 Timeout: TIMEOUT_CYC=16, tx_sent held 0 -> tx_send falls after 16 SEND cycles, err pulses once, then req_done pulses.
REQ-037 Reset mid-SEND: rst_n=0 for one cycle -> tx_send=0 next edge, no req_done; after reset with req_valid=4'b1001, requester 0 is granted first.
REQ-038 Four-phase guard: tx_sent stuck high after RELEASE -> the block stays in RELEASE with no done; when tx_sent drops, done pulses, then the next grant is issued.
